// File: rtl/axil_regbus_bridge.sv
// AXI4-Lite slave to single-outstanding req/ack register bus, with a timeout watchdog and fixed error responses.
// Optional statistics counters (err_cnt, timeout_cnt) are enabled by defining AXIL_BRIDGE_STATS_EN.
module axil_regbus_bridge #(
  parameter int          ADDR_W         = 20,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic              axilite_clk,
  input  logic              axilite_rst,
  input  logic [31:0]       s_axi_awaddr,
  input  logic [2:0]        s_axi_awprot,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [31:0]       s_axi_araddr,
  input  logic [2:0]        s_axi_arprot,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              reg_req,
  output logic              reg_wr,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [31:0]       reg_wdata,
  output logic [3:0]        reg_wstrb,
  input  logic              reg_ack,
  input  logic [31:0]       reg_rdata,
  input  logic              reg_err
`ifdef AXIL_BRIDGE_STATS_EN
  ,
  output logic [15:0]       err_cnt,
  output logic [15:0]       timeout_cnt
`endif
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUS   = 2'd1;
  localparam logic [1:0] S_WRESP = 2'd2;
  localparam logic [1:0] S_RRESP = 2'd3;
  localparam logic [1:0] R_OKAY   = 2'b00;
  localparam logic [1:0] R_SLVERR = 2'b10;
  localparam logic [1:0] R_DECERR = 2'b11;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d, ar_held_q, ar_held_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
  logic [31:0]       w_data_q, w_data_d;
  logic [3:0]        w_strb_q, w_strb_d;
  logic              last_wr_q, last_wr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              req_q, req_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic              wr_pend, rd_pend, pick_wr, err_evt, to_evt;

  assign s_axi_awready = ~aw_held_q & ~axilite_rst;
  assign s_axi_wready  = ~w_held_q  & ~axilite_rst;
  assign s_axi_arready = ~ar_held_q & ~axilite_rst;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign reg_req   = req_q;
  assign reg_wr    = wr_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wstrb = wstrb_q;

  assign wr_pend = aw_held_q & w_held_q;
  assign rd_pend = ar_held_q;
  // Alternation state only moves on contested cycles, so an uncontested issue never biases the next tie.
  assign pick_wr = wr_pend & (~rd_pend | ~last_wr_q);

  always_comb begin
    state_d = state_q;
    aw_held_d = aw_held_q; aw_addr_d = aw_addr_q;
    w_held_d = w_held_q; w_data_d = w_data_q; w_strb_d = w_strb_q;
    ar_held_d = ar_held_q; ar_addr_d = ar_addr_q;
    last_wr_d = last_wr_q;
    cnt_d = cnt_q;
    req_d = 1'b0; wr_d = wr_q; addr_d = addr_q; wdata_d = wdata_q; wstrb_d = wstrb_q;
    bvalid_d = bvalid_q; bresp_d = bresp_q;
    rvalid_d = rvalid_q; rresp_d = rresp_q; rdata_d = rdata_q;
    err_evt = 1'b0; to_evt = 1'b0;

    if (s_axi_awvalid && s_axi_awready) begin
      aw_held_d = 1'b1; aw_addr_d = s_axi_awaddr[ADDR_W-1:0];
    end
    if (s_axi_wvalid && s_axi_wready) begin
      w_held_d = 1'b1; w_data_d = s_axi_wdata; w_strb_d = s_axi_wstrb;
    end
    if (s_axi_arvalid && s_axi_arready) begin
      ar_held_d = 1'b1; ar_addr_d = s_axi_araddr[ADDR_W-1:0];
    end

    case (state_q)
      S_IDLE: begin
        if (wr_pend && rd_pend) last_wr_d = pick_wr;
        if (pick_wr) begin
          aw_held_d = 1'b0; w_held_d = 1'b0;
          if (aw_addr_q[1:0] != 2'b00) begin
            bvalid_d = 1'b1; bresp_d = R_DECERR; err_evt = 1'b1; state_d = S_WRESP;
          end else begin
            req_d = 1'b1; wr_d = 1'b1; addr_d = {aw_addr_q[ADDR_W-1:2], 2'b00};
            wdata_d = w_data_q; wstrb_d = w_strb_q; cnt_d = '0; state_d = S_BUS;
          end
        end else if (rd_pend) begin
          ar_held_d = 1'b0;
          if (ar_addr_q[1:0] != 2'b00) begin
            rvalid_d = 1'b1; rresp_d = R_DECERR; rdata_d = ERR_RDATA; err_evt = 1'b1;
            state_d = S_RRESP;
          end else begin
            req_d = 1'b1; wr_d = 1'b0; addr_d = {ar_addr_q[ADDR_W-1:2], 2'b00};
            cnt_d = '0; state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        cnt_d = cnt_q + 16'd1;
        if (reg_ack || cnt_q == TO_LAST) begin
          to_evt  = ~reg_ack;
          err_evt = ~reg_ack | reg_err;
          if (wr_q) begin
            bvalid_d = 1'b1; bresp_d = err_evt ? R_SLVERR : R_OKAY; state_d = S_WRESP;
          end else begin
            rvalid_d = 1'b1; rresp_d = err_evt ? R_SLVERR : R_OKAY;
            rdata_d = err_evt ? ERR_RDATA : reg_rdata; state_d = S_RRESP;
          end
        end
      end
      S_WRESP: if (s_axi_bready) begin bvalid_d = 1'b0; state_d = S_IDLE; end
      default: if (s_axi_rready) begin rvalid_d = 1'b0; state_d = S_IDLE; end
    endcase
  end

  always_ff @(posedge axilite_clk or posedge axilite_rst) begin
    if (axilite_rst) begin
      state_q <= S_IDLE;
      aw_held_q <= 1'b0; aw_addr_q <= '0;
      w_held_q <= 1'b0; w_data_q <= '0; w_strb_q <= '0;
      ar_held_q <= 1'b0; ar_addr_q <= '0;
      last_wr_q <= 1'b0; cnt_q <= '0;
      req_q <= 1'b0; wr_q <= 1'b0; addr_q <= '0; wdata_q <= '0; wstrb_q <= '0;
      bvalid_q <= 1'b0; bresp_q <= '0; rvalid_q <= 1'b0; rresp_q <= '0; rdata_q <= '0;
    end else begin
      state_q <= state_d;
      aw_held_q <= aw_held_d; aw_addr_q <= aw_addr_d;
      w_held_q <= w_held_d; w_data_q <= w_data_d; w_strb_q <= w_strb_d;
      ar_held_q <= ar_held_d; ar_addr_q <= ar_addr_d;
      last_wr_q <= last_wr_d; cnt_q <= cnt_d;
      req_q <= req_d; wr_q <= wr_d; addr_q <= addr_d; wdata_q <= wdata_d; wstrb_q <= wstrb_d;
      bvalid_q <= bvalid_d; bresp_q <= bresp_d; rvalid_q <= rvalid_d; rresp_q <= rresp_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef AXIL_BRIDGE_STATS_EN
  logic [15:0] err_cnt_q, to_cnt_q;
  always_ff @(posedge axilite_clk or posedge axilite_rst) begin
    if (axilite_rst) begin
      err_cnt_q <= '0; to_cnt_q <= '0;
    end else begin
      if (err_evt && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      if (to_evt && to_cnt_q != 16'hFFFF) to_cnt_q <= to_cnt_q + 16'd1;
    end
  end
  assign err_cnt     = err_cnt_q;
  assign timeout_cnt = to_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = err_evt ^ to_evt;
`endif

  // Upper address bits are decoded by the crossbar; prot is not used by the register bus.
  logic unused_in;
  assign unused_in = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[31:ADDR_W], s_axi_araddr[31:ADDR_W]};
endmodule

// File: tb/tb_axil_regbus_bridge.sv
// Scoreboard bench for axil_regbus_bridge: directed AXI-Lite traffic against a behavioural req/ack target.
module tb_axil_regbus_bridge;
  logic clk = 0, rst = 1;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata, reg_wdata, reg_rdata = 0;
  logic [2:0]  awprot = 0, arprot = 0;
  logic [3:0]  wstrb = 0, reg_wstrb;
  logic awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 1;
  logic arvalid = 0, arready, rvalid, rready = 1;
  logic [1:0] bresp, rresp;
  logic reg_req, reg_wr, reg_ack = 0, reg_err = 0;
  logic [19:0] reg_addr;
`ifdef AXIL_BRIDGE_STATS_EN
  logic [15:0] err_cnt, timeout_cnt;
`endif

  axil_regbus_bridge dut (
    .axilite_clk(clk), .axilite_rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .reg_req(reg_req), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wstrb(reg_wstrb), .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err)
`ifdef AXIL_BRIDGE_STATS_EN
    , .err_cnt(err_cnt), .timeout_cnt(timeout_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic wr; logic [19:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } req_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; } r_t;
  req_t       req_q[$];
  r_t         r_q[$];
  logic [1:0] b_q[$];
  int checks = 0, errors = 0, cyc = 0;

  int          ack_delay = 3;
  logic [31:0] tgt_rdata = 0;
  logic        tgt_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural target: acks ack_delay cycles after seeing reg_req; negative delay means never.
  always begin
    @(negedge clk);
    if (reg_req && !rst && ack_delay >= 0) begin
      repeat (ack_delay) @(negedge clk);
      reg_ack = 1; reg_err = tgt_err; reg_rdata = tgt_rdata;
      @(negedge clk);
      reg_ack = 0; reg_err = 0;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a request or a response.
  logic prev_req = 0, prev_stall = 0;
  r_t   prev_r;
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_req) begin
        req_t e;
        checks++;
        if (prev_req) begin
          errors++; $display("FAIL req_pulse: reg_req high two cycles, required one");
        end else if (req_q.size() == 0) begin
          errors++; $display("FAIL req_unexpected: addr=%h wr=%0d, required no request", reg_addr, reg_wr);
        end else begin
          e = req_q.pop_front();
          if (reg_wr !== e.wr || reg_addr !== e.addr ||
              (e.wr && (reg_wdata !== e.wdata || reg_wstrb !== e.wstrb))) begin
            errors++;
            $display("FAIL req_fields: wr=%0d addr=%h wdata=%h strb=%h, required wr=%0d addr=%h wdata=%h strb=%h",
                     reg_wr, reg_addr, reg_wdata, reg_wstrb, e.wr, e.addr, e.wdata, e.wstrb);
          end
        end
      end
      if (bvalid && bready) begin
        checks++;
        if (b_q.size() == 0) begin
          errors++; $display("FAIL b_unexpected: bresp=%b, required no response", bresp);
        end else begin
          logic [1:0] eb;
          eb = b_q.pop_front();
          if (bresp !== eb) begin errors++; $display("FAIL bresp: got %b, required %b", bresp, eb); end
        end
      end
      if (prev_stall) begin
        checks++;
        if (!rvalid || rdata !== prev_r.data || rresp !== prev_r.resp) begin
          errors++;
          $display("FAIL r_hold: rvalid=%0d rdata=%h rresp=%b, required 1 %h %b", rvalid, rdata, rresp,
                   prev_r.data, prev_r.resp);
        end
      end
      if (rvalid && rready) begin
        checks++;
        if (r_q.size() == 0) begin
          errors++; $display("FAIL r_unexpected: rdata=%h rresp=%b, required no response", rdata, rresp);
        end else begin
          r_t er;
          er = r_q.pop_front();
          if (rdata !== er.data || rresp !== er.resp) begin
            errors++; $display("FAIL rdata_rresp: got %h/%b, required %h/%b", rdata, rresp, er.data, er.resp);
          end
        end
      end
      prev_stall  = rvalid && !rready;
      prev_r.data = rdata; prev_r.resp = rresp;
    end
    prev_req = reg_req && !rst;
  end

  task automatic push_req(input logic wr, input logic [19:0] a, input logic [31:0] d, input logic [3:0] s);
    req_t e;
    e.wr = wr; e.addr = a; e.wdata = d; e.wstrb = s;
    req_q.push_back(e);
  endtask

  task automatic push_r(input logic [31:0] d, input logic [1:0] resp);
    r_t e;
    e.data = d; e.resp = resp;
    r_q.push_back(e);
  endtask

  task automatic axi_send(input bit do_aw, input logic [31:0] aw, input bit do_w, input logic [31:0] wd,
                          input logic [3:0] ws, input bit do_ar, input logic [31:0] ar);
    bit hs_aw, hs_w, hs_ar;
    int n = 0;
    @(negedge clk);
    if (do_aw) begin awaddr = aw; awvalid = 1; end
    if (do_w)  begin wdata = wd; wstrb = ws; wvalid = 1; end
    if (do_ar) begin araddr = ar; arvalid = 1; end
    while ((awvalid || wvalid || arvalid) && n < 100) begin
      hs_aw = awvalid && awready; hs_w = wvalid && wready; hs_ar = arvalid && arready;
      @(posedge clk); #1;
      if (hs_aw) awvalid = 0;
      if (hs_w)  wvalid = 0;
      if (hs_ar) arvalid = 0;
      n++;
    end
    if (n >= 100) begin
      checks++; errors++; $display("FAIL handshake: not accepted within 100 cycles");
      awvalid = 0; wvalid = 0; arvalid = 0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((req_q.size() + r_q.size() + b_q.size()) != 0 && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL drain: %0d/%0d/%0d expectations left, required 0", req_q.size(), r_q.size(), b_q.size());
      req_q.delete(); r_q.delete(); b_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_req(output int t);
    int n = 0;
    @(negedge clk);
    while (!reg_req && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin checks++; errors++; $display("FAIL wait_req: no reg_req within 500 cycles"); end
    t = cyc;
  endtask

  initial begin
    int t0, t1, n;
    repeat (3) @(negedge clk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, reg_req} !== 6'b0 || {bresp, rresp} !== 4'b0 ||
        rdata !== 0 || reg_addr !== 0 || reg_wdata !== 0 || reg_wstrb !== 0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b%b%b bv=%0d rv=%0d req=%0d rdata=%h addr=%h, required all 0",
               awready, wready, arready, bvalid, rvalid, reg_req, rdata, reg_addr);
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++; $display("FAIL ready_after_reset: %b%b%b, required 111", awready, wready, arready);
    end

    // Plain write, ack after 3 cycles
    ack_delay = 3; tgt_err = 0;
    push_req(1, 20'h01000, 32'h20, 4'hF); b_q.push_back(2'b00);
    axi_send(1, 32'h0000_1000, 1, 32'h20, 4'hF, 0, 0);
    drain();

    // Read with rready stalled for three cycles
    tgt_rdata = 32'h1234_5678; rready = 0;
    push_req(0, 20'h00004, 0, 0); push_r(32'h1234_5678, 2'b00);
    axi_send(0, 0, 0, 0, 0, 1, 32'h0000_0004);
    n = 0;
    while (!rvalid && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    rready = 1;
    drain();

    // Target never acks: timeout after 256 cycles, then normal read
    ack_delay = -1;
    push_req(0, 20'h00008, 0, 0); push_r(32'hDEAD_BEEF, 2'b10);
    axi_send(0, 0, 0, 0, 0, 1, 32'h0000_0008);
    wait_req(t0);
    n = 0;
    while (!rvalid && n < 400) begin @(negedge clk); n++; end
    t1 = cyc;
    checks++;
    if (t1 - t0 != 256) begin errors++; $display("FAIL timeout_latency: %0d cycles, required 256", t1 - t0); end
    drain();
    ack_delay = 2; tgt_rdata = 32'hA5A5_0001;
    push_req(0, 20'h0000C, 0, 0); push_r(32'hA5A5_0001, 2'b00);
    axi_send(0, 0, 0, 0, 0, 1, 32'h0000_000C);
    drain();

    // Unaligned accesses: DECERR with no bus request
    b_q.push_back(2'b11);
    axi_send(1, 32'h0000_0002, 1, 32'h55, 4'hF, 0, 0);
    drain();
    push_r(32'hDEAD_BEEF, 2'b11);
    axi_send(0, 0, 0, 0, 0, 1, 32'h0000_0003);
    drain();

    // Target error responses
    tgt_err = 1; ack_delay = 0;
    push_req(1, 20'h00010, 32'h0BAD_0001, 4'h3); b_q.push_back(2'b10);
    axi_send(1, 32'h0000_0010, 1, 32'h0BAD_0001, 4'h3, 0, 0);
    drain();
    push_req(0, 20'h00014, 0, 0); push_r(32'hDEAD_BEEF, 2'b10);
    axi_send(0, 0, 0, 0, 0, 1, 32'h0000_0014);
    drain();
    tgt_err = 0;

    // Simultaneous write and read, twice: write first, then read first
    ack_delay = 1; tgt_rdata = 32'hCAFE_0001;
    push_req(1, 20'h00100, 32'h11, 4'hF); push_req(0, 20'h00104, 0, 0);
    b_q.push_back(2'b00); push_r(32'hCAFE_0001, 2'b00);
    axi_send(1, 32'h0000_0100, 1, 32'h11, 4'hF, 1, 32'h0000_0104);
    drain();
    push_req(0, 20'h00108, 0, 0); push_req(1, 20'h0010C, 32'h22, 4'hC);
    b_q.push_back(2'b00); push_r(32'hCAFE_0001, 2'b00);
    axi_send(1, 32'h0000_010C, 1, 32'h22, 4'hC, 1, 32'h0000_0108);
    drain();

    // W arrives 5 cycles before AW
    push_req(1, 20'h00200, 32'h33, 4'hF); b_q.push_back(2'b00);
    axi_send(0, 0, 1, 32'h33, 4'hF, 0, 0);
    repeat (5) @(negedge clk);
    axi_send(1, 32'h0000_0200, 0, 0, 0, 0, 0);
    drain();

    // Reset while the request pulse is on the bus
    ack_delay = -1;
    push_req(1, 20'h00300, 32'h44, 4'hF);
    axi_send(1, 32'h0000_0300, 1, 32'h44, 4'hF, 0, 0);
    wait_req(t0);
    #2 rst = 1;
    #1;
    checks++;
    if (reg_req !== 0 || bvalid !== 0 || rvalid !== 0 || awready !== 0) begin
      errors++;
      $display("FAIL async_reset: req=%0d bv=%0d rv=%0d awready=%0d, required 0 0 0 0", reg_req, bvalid, rvalid, awready);
    end
    repeat (2) @(negedge clk);
    rst = 0; ack_delay = 1;
    push_req(1, 20'h00304, 32'h55, 4'hF); b_q.push_back(2'b00);
    axi_send(1, 32'h0000_0304, 1, 32'h55, 4'hF, 0, 0);
    drain();

    repeat (20) @(negedge clk);
    checks++;
    if (req_q.size() + r_q.size() + b_q.size() != 0) begin
      errors++; $display("FAIL leftover: %0d expectations pending, required 0", req_q.size() + r_q.size() + b_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
